// File: rtl/sega_joy_scanner.sv
// Scans two Sega joystick ports by toggling the shared select line once per tick
// and assembles 12-bit active-low button words, detecting 3/6-button and SMS pads.
module sega_joy_scanner #(
    parameter int SYNC_INPUTS = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        tick,
    input  logic [5:0]  joy1_i,
    input  logic [5:0]  joy2_i,
    output logic        joy_p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic        six1_o,
    output logic        six2_o,
    output logic        frame_o
);

    logic [5:0] pins1;
    logic [5:0] pins2;
    logic [7:0] step;
    logic       pend1;
    logic       pend2;

    if (SYNC_INPUTS != 0) begin : g_sync
        logic [5:0] sync1_p0, sync1_p1;
        logic [5:0] sync2_p0, sync2_p1;

        // Idle level of the pins is high, so the synchronizers reset to all ones.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                sync1_p0 <= 6'h3F;
                sync1_p1 <= 6'h3F;
                sync2_p0 <= 6'h3F;
                sync2_p1 <= 6'h3F;
            end else begin
                sync1_p0 <= joy1_i;
                sync1_p1 <= sync1_p0;
                sync2_p0 <= joy2_i;
                sync2_p1 <= sync2_p0;
            end
        end

        assign pins1 = sync1_p1;
        assign pins2 = sync2_p1;
    end else begin : g_direct
        assign pins1 = joy1_i;
        assign pins2 = joy2_i;
    end

    // Pin layout {p9,p6,right,left,down,up}; word layout {M,X,Y,Z,S,A,C,B,R,L,D,U}.
    function automatic logic [11:0] next_word(input logic [7:0]  st,
                                              input logic [5:0]  p,
                                              input logic        pend,
                                              input logic [11:0] w);
        logic [11:0] n;
        n = w;
        case (st)
            8'd2: n[5:0] = p;
            8'd3: begin
                if (p[3:2] == 2'b00) n[7:6] = p[5:4];
                else                 n[7:4] = {2'b11, p[5:4]};
            end
            8'd6: n[11:8] = pend ? p[3:0] : 4'hF;
            default: n = w;
        endcase
        return n;
    endfunction

    function automatic logic next_pend(input logic [7:0] st,
                                       input logic [5:0] p,
                                       input logic       pend);
        logic n;
        n = pend;
        if (st == 8'd2)                         n = 1'b0;
        else if (st == 8'd5 && p[3:0] == 4'h0)  n = 1'b1;
        return n;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            step     <= 8'd0;
            joy_p7_o <= 1'b1;
            joy1_o   <= 12'hFFF;
            joy2_o   <= 12'hFFF;
            six1_o   <= 1'b0;
            six2_o   <= 1'b0;
            frame_o  <= 1'b0;
            pend1    <= 1'b0;
            pend2    <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (tick) begin
                step     <= step + 8'd1;
                // Select is low on even steps of the active window, high otherwise.
                joy_p7_o <= (step > 8'd6) || step[0];
                joy1_o   <= next_word(step, pins1, pend1, joy1_o);
                joy2_o   <= next_word(step, pins2, pend2, joy2_o);
                pend1    <= next_pend(step, pins1, pend1);
                pend2    <= next_pend(step, pins2, pend2);
                if (step == 8'd6) begin
                    six1_o  <= pend1;
                    six2_o  <= pend2;
                    frame_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Randomized and directed bench for sega_joy_scanner against a word-level model
// of one full scan built from the per-step capture rules.
module tb_sega_joy_scanner;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        tick;
    logic [5:0]  joy1_i;
    logic [5:0]  joy2_i;
    logic        joy_p7_o;
    logic [11:0] joy1_o;
    logic [11:0] joy2_o;
    logic        six1_o;
    logic        six2_o;
    logic        frame_o;

    sega_joy_scanner #(.SYNC_INPUTS(1)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tick     (tick),
        .joy1_i   (joy1_i),
        .joy2_i   (joy2_i),
        .joy_p7_o (joy_p7_o),
        .joy1_o   (joy1_o),
        .joy2_o   (joy2_o),
        .six1_o   (six1_o),
        .six2_o   (six2_o),
        .frame_o  (frame_o)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passed = 0;

    logic [5:0]  pin1 [7];
    logic [5:0]  pin2 [7];
    logic [12:0] exp1;
    logic [12:0] exp2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Result of one scan as {six, word}, from the pin values seen at steps 2, 3, 5, 6.
    function automatic logic [12:0] model(input logic [5:0] a2, input logic [5:0] a3,
                                          input logic [5:0] a5, input logic [5:0] a6);
        logic        md;
        logic        six;
        logic [11:0] w;
        md  = (a3[3] == 1'b0) && (a3[2] == 1'b0);
        six = (a5[3:0] == 4'h0);
        w[3:0]  = a2[3:0];
        w[5:4]  = md ? a2[5:4] : a3[5:4];
        w[7:6]  = md ? a3[5:4] : 2'b11;
        w[11:8] = six ? a6[3:0] : 4'hF;
        return {six, w};
    endfunction

    function automatic logic exp_p7(input int s);
        return (s % 2 == 1) || (s >= 7);
    endfunction

    task automatic set_expect();
        exp1 = model(pin1[2], pin1[3], pin1[5], pin1[6]);
        exp2 = model(pin2[2], pin2[3], pin2[5], pin2[6]);
    endtask

    // Present pins long enough to clear the synchronizer, then give one tick.
    task automatic tick_step(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk_sys);
        joy1_i = a;
        joy2_i = b;
        repeat (2) @(negedge clk_sys);
        tick = 1'b1;
        @(negedge clk_sys);
        tick = 1'b0;
    endtask

    task automatic run_steps(input int from);
        logic [5:0] a;
        logic [5:0] b;
        for (int s = from; s < 256; s++) begin
            a = (s < 7) ? pin1[s] : 6'($urandom);
            b = (s < 7) ? pin2[s] : 6'($urandom);
            tick_step(a, b);
            check("p7", 32'(joy_p7_o), 32'(exp_p7(s)));
            check("frame", 32'(frame_o), 32'(s == 6));
            if (s == 6) begin
                check("joy1_scan", 32'(joy1_o), 32'(exp1[11:0]));
                check("joy2_scan", 32'(joy2_o), 32'(exp2[11:0]));
                check("six1_scan", 32'(six1_o), 32'(exp1[12]));
                check("six2_scan", 32'(six2_o), 32'(exp2[12]));
                @(negedge clk_sys);
                check("frame_one_cycle", 32'(frame_o), 32'd0);
            end
        end
        check("joy1_hold", 32'(joy1_o), 32'(exp1[11:0]));
        check("joy2_hold", 32'(joy2_o), 32'(exp2[11:0]));
        check("six1_hold", 32'(six1_o), 32'(exp1[12]));
        check("six2_hold", 32'(six2_o), 32'(exp2[12]));
    endtask

    task automatic idle_pins();
        for (int s = 0; s < 7; s++) begin
            pin1[s] = 6'h3F;
            pin2[s] = 6'h3F;
        end
    endtask

    function automatic logic [5:0] shape(input logic [5:0] p, input int s, input int kind);
        logic [5:0] r;
        r = p;
        if (s == 3 && (kind == 1 || kind == 2)) r[3:2] = 2'b00;
        if (s == 3 && kind == 3)                r[3:2] = 2'b11;
        if (s == 5 && kind == 2)                r[3:0] = 4'h0;
        return r;
    endfunction

    initial begin
        int k1;
        int k2;
        int fc;
        logic [5:0] c1;
        logic [5:0] c2;

        reset  = 1'b1;
        tick   = 1'b0;
        joy1_i = 6'h3F;
        joy2_i = 6'h3F;
        repeat (3) @(negedge clk_sys);
        check("rst_p7", 32'(joy_p7_o), 32'd1);
        check("rst_joy1", 32'(joy1_o), 32'hFFF);
        check("rst_joy2", 32'(joy2_o), 32'hFFF);
        check("rst_six", 32'({six1_o, six2_o}), 32'd0);
        check("rst_frame", 32'(frame_o), 32'd0);
        reset = 1'b0;

        // Idle pins.
        idle_pins();
        set_expect();
        run_steps(0);
        check("idle_joy1", 32'(joy1_o), 32'hFFF);

        // 3-button pad with A+Up on port 1, 6-button pad with X on port 2.
        idle_pins();
        pin1[2] = 6'h3E;
        pin1[3] = 6'h23;
        pin2[5] = 6'h30;
        pin2[6] = 6'h3B;
        set_expect();
        run_steps(0);
        check("md3_joy1", 32'(joy1_o), 32'hFBE);
        check("md3_six1", 32'(six1_o), 32'd0);
        check("six_joy2", 32'(joy2_o), 32'hBFF);
        check("six_six2", 32'(six2_o), 32'd1);

        // Master System pad on port 1.
        idle_pins();
        pin1[3] = 6'h2F;
        set_expect();
        run_steps(0);
        check("sms_joy1_hi", 32'(joy1_o[7:4]), 32'hE);

        // Reset in the middle of a scan, after steps 2 and 3 captured data.
        idle_pins();
        pin1[2] = 6'h3E;
        pin1[3] = 6'h23;
        for (int s = 0; s < 4; s++) tick_step(pin1[s], pin2[s]);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("midrst_joy1", 32'(joy1_o), 32'hFFF);
        check("midrst_p7", 32'(joy_p7_o), 32'd1);
        @(negedge clk_sys);
        reset = 1'b0;
        idle_pins();
        set_expect();
        run_steps(0);

        // Randomized scans with independently chosen pad type per port.
        for (int n = 0; n < 16; n++) begin
            k1 = int'($urandom_range(0, 3));
            k2 = int'($urandom_range(0, 3));
            for (int s = 0; s < 7; s++) begin
                pin1[s] = shape(6'($urandom), s, k1);
                pin2[s] = shape(6'($urandom), s, k2);
            end
            set_expect();
            run_steps(0);
        end

        // Tick held high for the seven active steps back to back.
        c1 = 6'($urandom);
        c2 = 6'h00;
        for (int s = 0; s < 7; s++) begin
            pin1[s] = c1;
            pin2[s] = c2;
        end
        set_expect();
        @(negedge clk_sys);
        joy1_i = c1;
        joy2_i = c2;
        repeat (3) @(negedge clk_sys);
        fc = 0;
        tick = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_sys);
            if (frame_o) fc++;
        end
        tick = 1'b0;
        check("burst_frame_at_6", 32'(frame_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            if (frame_o) fc++;
        end
        check("burst_frames", 32'(fc), 32'd1);
        check("burst_p7", 32'(joy_p7_o), 32'd0);
        check("burst_joy1", 32'(joy1_o), 32'(exp1[11:0]));
        check("burst_joy2", 32'(joy2_o), 32'(exp2[11:0]));
        check("burst_six2", 32'(six2_o), 32'd1);
        run_steps(7);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sega_joy_scanner.md
SEGA_JOY_SCANNER -- requirements
Module: sega_joy_scanner

Interface
REQ-001 SHALL have parameter SYNC_INPUTS, default 1: 1 = two-flop synchronizer on all joystick pins; 0 = pins used directly.
REQ-002 SHALL have port clk_sys  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle scan-step strobe (hsync-rate), synchronous to clk_sys.
REQ-005 SHALL have port joy1_i  input  6  port-1 pins {p9,p6,right,left,down,up}, active low.
REQ-006 SHALL have port joy2_i  input  6  port-2 pins, same layout as joy1_i.
REQ-007 SHALL have port joy_p7_o  output  1  select line shared by both ports.
REQ-008 SHALL have port joy1_o  output  12  port-1 buttons {M,X,Y,Z,S,A,C,B,R,L,D,U}, active low.
REQ-009 SHALL have port joy2_o  output  12  port-2 buttons, same layout.
REQ-010 SHALL have port six1_o / six2_o  output  1 each  port detected as 6-button pad.
REQ-011 SHALL have port frame_o  output  1  one-cycle pulse on scan completion.

Function
REQ-012 SHALL keep an 8-bit step counter that advances only on tick; 255 wraps to 0.
REQ-013 All actions below SHALL occur on the clk_sys edge where tick=1, keyed by the current step, using synchronized pin values; outputs registered, visible the following cycle.
REQ-014 Step 0: p7<=0.
REQ-015 Step 1: p7<=1.
REQ-016 Step 2: per port, bits[3:0]<={R,L,D,U}, bits[5:4]<={p9,p6}; clear internal six-pending flag; p7<=0.
REQ-017 Step 3: per port, if right=0 and left=0 (MD pad), bits[7:6]<={p9,p6}; otherwise bits[7:4]<={1,1,p9,p6} (Master System); p7<=1.
REQ-018 Step 4: p7<=0.
REQ-019 Step 5: per port, six-pending<=1 when up, down, left, right all 0; p7<=1.
REQ-020 Step 6: per port, if six-pending, bits[11:8]<={right,left,down,up}, else bits[11:8]<=4'hF; sixN_o<=six-pending; p7<=0; frame_o pulses the next cycle.
REQ-021 Steps 7-255: p7<=1; no capture.
REQ-022 Ports SHALL be decoded independently; one port's pad type SHALL NOT affect the other.
REQ-023 Cycles without tick SHALL hold all state and outputs.
REQ-024 tick asserted on consecutive cycles SHALL advance one step per cycle; no step skipped or repeated.
REQ-025 Pin changes between steps 2 and 6 SHALL corrupt only the fields captured after the change; no lock-up.

Reset
REQ-026 While reset=1: step=0, joy_p7_o=1, joy1_o=joy2_o=12'hFFF, six1_o=six2_o=0, frame_o=0, six-pending=0, synchronizers=all 1.
REQ-027 Reset released mid-scan SHALL restart at step 0 on the next tick; partially captured data SHALL be discarded.

Verification
REQ-028 Idle pins all 1, 256 ticks -> joy_p7_o sequence 0,1,0,1,0,1,0 then 1 for steps 7-255; joy1_o=12'hFFF, six1_o=0, one frame_o pulse.
REQ-029 Port 1 MD 3-button pad, A and Up held (model drives right=left=0 on step 3) -> joy1_o=12'hFBE, six1_o=0.
REQ-030 Port 2 6-button pad, X held (all dirs 0 at step 5, left=0 at step 6) -> six2_o=1, joy2_o[11:8]=4'hB; joy1_o unaffected.
REQ-031 Master System pad on port 1, p6=0 at step 3 with right/left=1 -> joy1_o[7:4]=4'hE.
REQ-032 Reset asserted at step 4 then released -> outputs 12'hFFF immediately, next tick treated as step 0 (p7<=0).
REQ-033 tick held high 7 cycles -> steps 0-6 complete in 7 cycles, frame_o pulses once, data correct.
